capture_sequencer: RTL
======================

# capture_sequencer

Sequences one digitizer capture into the AXI-Stream S2MM path of the DMA. Each software start produces one packet of exactly the programmed byte count, terminated by `tlast`. Samples come from the ADC front end, or from an internal ramp when test mode is selected. The block sits between the ADC sample interface (already in the `clk` domain) and the DMA stream input, and is driven by the control/packet-size registers at 0x6000_0000 / 0x6000_0008.

## Interface
- `FIFO_DEPTH`, 16: output beat FIFO depth, power of two, ≥4.
- `SIZE_W`, 32: width of the packet-size register.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse (control bit 0 write).
- `stop` in 1: one-cycle pulse, early terminate.
- `test_mode` in 1: control bit 1, sampled on accepted `start`.
- `packet_size` in SIZE_W: bytes per packet, sampled on accepted `start`.
- `adc_data` in 16: ADC sample.
- `adc_valid` in 1: sample strobe.
- `m_axis_tdata` out 32: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: last beat of packet.
- `busy` out 1: capture in progress.
- `done` out 1: sticky, packet fully delivered.
- `overflow` out 1: sticky, beat dropped on full FIFO.
- `size_err` out 1: sticky, illegal `packet_size`.

## Operation
- States: IDLE, CAPTURE, TERM, DRAIN.
- IDLE + `start`:
  - If `packet_size` == 0 or `packet_size[1:0]` != 0: set `size_err`, stay IDLE.
  - Otherwise: latch `beats_rem = packet_size >> 2` and the mode; clear `done`, `overflow` and `size_err`; zero the ramp counter and pack phase; go to CAPTURE.
- `start` outside IDLE is ignored. `stop` in IDLE or DRAIN is ignored.
- Sample source:
  - `test_mode = 0`: `adc_data`.
  - `test_mode = 1`: 16-bit ramp, value 0 on the first `adc_valid`, +1 per `adc_valid`, wraps 0xFFFF→0x0000.
- Packing: even-phase sample goes to `tdata[15:0]`; the next sample goes to `[31:16]` and completes a beat.
- CAPTURE, beat completed:
  - FIFO not full: push the beat and decrement `beats_rem`. If `beats_rem` was 1, tag the beat `tlast` and go to DRAIN.
  - FIFO full: drop the beat, set `overflow`, leave `beats_rem` unchanged. Packet length stays exact; data becomes discontinuous.
- CAPTURE + `stop`: go to TERM. TERM pushes one final beat when the FIFO has space, then goes to DRAIN.
  - The final beat holds the pending half-sample in `[15:0]` with zeros above, or all zeros if no half-sample is pending.
  - The final beat always carries `tlast` and is never dropped.
- `adc_valid` in TERM or DRAIN is discarded.
- If `stop` and the last-beat completion occur in the same cycle, the normal last beat wins and `stop` is ignored.
- DRAIN: when the FIFO is empty and the `tlast` beat has handshaken, set `done`, go to IDLE.
- `busy` = 1 in any state other than IDLE.
- The FIFO is first-word-fall-through: `tvalid` = !empty, and `tdata`/`tlast` show the head entry. A beat pops on `tvalid & tready`.
- AXIS rule: once `tvalid` is high, it and `tdata`/`tlast` stay stable until the handshake.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0. Reset mid-capture discards the FIFO without emitting `tlast`.
- Reset and `start` in the same cycle: reset wins.
- State changes to CAPTURE on the cycle after the `start` pulse. A same-cycle `adc_valid` is not captured.
- Latency: a beat completed by the `adc_valid` at edge N is pushed at N and shows as `tvalid` = 1 after edge N+1.
- A push and a pop in the same cycle on a full FIFO: the pop frees space, so the push succeeds and no overflow is flagged.
- Throughput: one beat per 2 samples, up to 1 beat/cycle out.
- `done` rises on the cycle after the `tlast` handshake; `busy` falls on that same cycle.
- Width: `beats_rem` is SIZE_W-2 bits, giving a maximum packet of 2^SIZE_W−4 bytes.

## Test plan
- Test mode, `packet_size` = 65536, `tready` held 1: 16384 beats, first beat 0x0001_0000, beat k = {2k+1, 2k}, `tlast` only on beat 16383, then `done` = 1.
- `packet_size` = 4: exactly 1 beat with `tlast`. `packet_size` = 6 or 0: `size_err` = 1, no `tvalid`, `busy` stays 0.
- Test mode, size 1024, `tready` = 0 for 40 samples (20 beats, depth 16): `overflow` = 1; still exactly 256 beats delivered with `tlast` on the last; a ramp gap is present.
- `stop` after 3 samples, size 4096: 2 beats delivered, 0x0001_0000 then 0x0000_0002 with `tlast`, then `done` = 1.
- `reset` asserted during DRAIN with 5 beats queued: next cycle `tvalid` = 0, `busy` = 0, `done` = 0. A new `start` then runs normally.
- Random `tready` with 20% stalls while `tvalid` is high: `tdata`/`tlast` stable, no beat duplicated or lost.

Source files
------------

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if
// AXI-Stream beat channel carried from the capture sequencer to the DMA S2MM input.
//   tdata  : 32-bit beat, two packed 16-bit samples
//   tvalid : beat available (head of the output FIFO)
//   tready : sink accepts the beat
//   tlast  : final beat of the packet
// Modports: master = sequencer side, slave = DMA side.
interface capture_sequencer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer
// Turns one software start into one AXI-Stream packet of exactly packet_size bytes.
// The 16-bit samples come from the ADC or from an internal ramp. They are packed in
// pairs into 32-bit beats and queued in a first-word-fall-through FIFO.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, stop           : one-cycle control pulses
//   test_mode, packet_size: sampled when a start is accepted
//   adc_data, adc_valid   : sample input
//   m_axis                : stream output (master modport)
//   busy                  : capture in progress (state != IDLE)
//   done                  : sticky, packet fully delivered
//   overflow              : sticky, a beat was dropped because the FIFO was full
//   size_err              : sticky, a start was rejected for an illegal size
module capture_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int SIZE_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   test_mode,
    input  logic [SIZE_W-1:0]      packet_size,
    input  logic [15:0]            adc_data,
    input  logic                   adc_valid,
    capture_sequencer_if.master    m_axis,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   size_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = SIZE_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_TERM, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beats_rem_q;
    logic            mode_q;
    logic [15:0]     ramp_q;
    logic            phase_q;
    logic [15:0]     half_q;
    logic            done_q, ovf_q, size_err_q;

    // A completed beat is staged for one cycle before it is written into the
    // FIFO, so it appears on tvalid one edge after the completing sample.
    logic            push_q;
    logic [32:0]     stage_q;              // {tlast, tdata}

    logic [32:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;

    logic            fifo_empty, pop, has_space, size_ok, start_ok;
    logic            beat_done, last_beat, term_push, drain_end;
    logic [AW:0]     fifo_cnt;
    logic [AW+1:0]   occ;
    logic [15:0]     sample;
    logic [32:0]     head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign pop        = !fifo_empty && m_axis.tready;
    // Occupancy after this edge, counting the staged beat. A same-cycle pop
    // frees an entry, so a push into a full FIFO that is being drained succeeds.
    assign occ        = (AW+2)'(fifo_cnt) + (AW+2)'(push_q) - (AW+2)'(pop);
    assign has_space  = occ < (AW+2)'(FIFO_DEPTH);

    assign size_ok    = (packet_size != '0) && (packet_size[1:0] == 2'b00);
    assign start_ok   = (state_q == S_IDLE) && start && size_ok;
    assign sample     = mode_q ? ramp_q : adc_data;
    assign beat_done  = (state_q == S_CAPTURE) && adc_valid && phase_q;
    assign last_beat  = beat_done && has_space && (beats_rem_q == BW'(1));
    assign term_push  = (state_q == S_TERM) && has_space;
    // The tlast beat is always the final FIFO entry, so popping it means the FIFO empties.
    assign drain_end  = (state_q == S_DRAIN) && pop && m_axis.tlast;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_ok) state_d = S_CAPTURE;
            // A last beat completing in the same cycle as stop takes priority.
            S_CAPTURE: if (last_beat) state_d = S_DRAIN;
                       else if (stop) state_d = S_TERM;
            S_TERM:    if (has_space) state_d = S_DRAIN;
            S_DRAIN:   if (drain_end) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Capture datapath, packing and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            beats_rem_q <= '0;
            mode_q      <= 1'b0;
            ramp_q      <= '0;
            phase_q     <= 1'b0;
            half_q      <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            size_err_q  <= 1'b0;
            push_q      <= 1'b0;
            stage_q     <= '0;
        end else begin
            push_q <= 1'b0;
            if (start_ok) begin
                beats_rem_q <= packet_size[SIZE_W-1:2];
                mode_q      <= test_mode;
                ramp_q      <= '0;
                phase_q     <= 1'b0;
                done_q      <= 1'b0;
                ovf_q       <= 1'b0;
                size_err_q  <= 1'b0;
            end else if (state_q == S_IDLE && start) begin
                size_err_q  <= 1'b1;
            end

            if (state_q == S_CAPTURE && adc_valid) begin
                ramp_q  <= ramp_q + 16'd1;
                phase_q <= ~phase_q;
                if (!phase_q) begin
                    half_q <= sample;
                end else if (has_space) begin
                    push_q      <= 1'b1;
                    stage_q     <= {beats_rem_q == BW'(1), sample, half_q};
                    beats_rem_q <= beats_rem_q - BW'(1);
                end else begin
                    // Dropped beat: the count is untouched so the packet length stays exact.
                    ovf_q <= 1'b1;
                end
            end

            if (term_push) begin
                push_q  <= 1'b1;
                stage_q <= {1'b1, 16'h0000, phase_q ? half_q : 16'h0000};
            end

            if (drain_end) done_q <= 1'b1;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_q) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage. The staged push never overwrites a live entry because
    // has_space already counted it.
    always_ff @(posedge clk) begin
        if (push_q) mem_q[wr_ptr_q[AW-1:0]] <= stage_q;
    end

    assign head          = fifo_empty ? 33'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = head[31:0];
    assign m_axis.tlast  = head[32];

    assign done     = done_q;
    assign overflow = ovf_q;
    assign size_err = size_err_q;
endmodule
